quant_mult_arbiter: RTL and testbench

Shared fixed-point multiply/dequantize engine for the FM radio datapath. It time-multiplexes one `DATA_WIDTH`-bit signed multiplier between `NUM_REQ` requesters, such as volume scaling, de-emphasis gain and FIR coefficient taps. A round-robin arbiter selects the requester, a two-stage valid/ready pipeline computes each product, and responses are tagged with the requester index. Arithmetic matches the package quantization rules: Q(`BITS`) operands, and the product is dequantized by integer division by 2^`BITS`.

---
 rtl/quant_mult_arbiter.sv | 140 ++++++++++++++
 tb/tb_quant_mult_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/quant_mult_arbiter.sv
// rtl/quant_mult_arbiter.sv - round-robin shared Q-format multiply/dequantize engine
//
// Purpose: one signed DATA_WIDTH multiplier shared by NUM_REQ requesters.
// A combinational round-robin arbiter feeds a two-stage valid/ready pipeline
// (S1 operand register, S2 output register). The product is divided by
// 2^BITS with truncation toward zero and wrapped to DATA_WIDTH bits.
//
// Ports:
//   clock, reset_n        clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b           flattened operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   resp_valid/resp_ready result handshake
//   resp_id/resp_data     owning requester index and dequantized product
module quant_mult_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [ID_WIDTH:0] NREQ = (ID_WIDTH + 1)'(NUM_REQ);
  localparam logic signed [PW-1:0] BIAS = {{(PW - BITS){1'b0}}, {BITS{1'b1}}};

  logic [ID_WIDTH-1:0]          ptr_q, ptr_d;
  logic                         s1_valid_q, s1_valid_d;
  logic [ID_WIDTH-1:0]          s1_id_q, s1_id_d;
  logic signed [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic signed [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
  logic                         resp_valid_q, resp_valid_d;
  logic [ID_WIDTH-1:0]          resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0]        resp_data_q, resp_data_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] gnt_id;
  logic                gnt_found;
  logic [ID_WIDTH:0]   scan;
  logic [ID_WIDTH:0]   ptr_next;

  logic s2_free, s1_adv, accept, hs;

  logic signed [PW-1:0] prod, prod_adj, quot;
  logic                 neg_frac;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; the first valid requester wins.
  always_comb begin
    grant     = '0;
    gnt_id    = '0;
    gnt_found = 1'b0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (ID_WIDTH + 1)'(k);
      if (scan >= NREQ) scan = scan - NREQ;
      if (!gnt_found && req_valid[scan[ID_WIDTH-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = scan[ID_WIDTH-1:0];
      end
    end
    if (gnt_found) grant[gnt_id] = 1'b1;
    ptr_next = {1'b0, gnt_id} + (ID_WIDTH + 1)'(1);
    if (ptr_next == NREQ) ptr_next = '0;
  end

  assign s2_free = !resp_valid_q || resp_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign accept  = !s1_valid_q || s1_adv;
  // reset_n gates the grant so nothing looks accepted while reset is held.
  assign req_ready = (accept && reset_n) ? grant : '0;
  assign hs        = accept && reset_n && gnt_found;

  // Division by 2^BITS truncating toward zero: negative products with a
  // nonzero fraction are biased up by 2^BITS-1 before the arithmetic shift.
  assign prod     = PW'(s1_a_q) * PW'(s1_b_q);
  assign neg_frac = prod[PW-1] && (|prod[BITS-1:0]);
  assign prod_adj = prod + (neg_frac ? BIAS : '0);
  assign quot     = prod_adj >>> BITS;

  always_comb begin
    ptr_d        = ptr_q;
    s1_valid_d   = s1_valid_q && !s1_adv;
    s1_id_d      = s1_id_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    if (hs) begin
      ptr_d      = ptr_next[ID_WIDTH-1:0];
      s1_valid_d = 1'b1;
      s1_id_d    = gnt_id;
      s1_a_d     = req_a[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      s1_b_d     = req_b[gnt_id*DATA_WIDTH +: DATA_WIDTH];
    end
    if (s1_adv) begin
      resp_valid_d = 1'b1;
      resp_id_d    = s1_id_q;
      resp_data_d  = quot[DATA_WIDTH-1:0];
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_quant_mult_arbiter.sv
// tb/tb_quant_mult_arbiter.sv - self-checking bench for quant_mult_arbiter
module tb_quant_mult_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IW-1:0]     resp_id;
  logic [DW-1:0]     resp_data;

  quant_mult_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BITS(10)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    int                 id;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [31:0] exp;
  } vec_t;

  vec_t        vecs[10];
  int          checks = 0;
  int          errors = 0;
  int          idx;
  int          got;
  logic [31:0] q[$];
  logic [31:0] exp_front;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic do_single(input vec_t v);
    req_a[v.id*DW +: DW] = v.a;
    req_b[v.id*DW +: DW] = v.b;
    req_valid = NR'(1) << v.id;
    #1;
    chk("vec_req_ready", 32'(req_ready), 32'(NR'(1) << v.id));
    tick();
    req_valid = '0;
    #1;
    chk("vec_latency_s1", 32'(resp_valid), 32'd0);
    tick();
    #1;
    chk("vec_resp_valid", 32'(resp_valid), 32'd1);
    chk("vec_resp_data", resp_data, v.exp);
    chk("vec_resp_id", 32'(resp_id), 32'(v.id));
    tick();
  endtask

  initial begin
    vecs[0] = '{0, 1024, 512, 512};
    vecs[1] = '{1, -1536, 1024, -1536};
    vecs[2] = '{2, -3, 1, 0};
    vecs[3] = '{3, 3, 1, 0};
    vecs[4] = '{0, -2048, -2048, 4096};
    vecs[5] = '{1, -1025, 1, -1};
    vecs[6] = '{2, 5000, 3000, 14648};
    vecs[7] = '{3, -5000, 3000, -14648};
    vecs[8] = '{0, 32'h7fffffff, 2048, 32'hfffffffe};
    vecs[9] = '{1, -1, 1023, 0};

    reset_n    = 1'b0;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    tick();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    req_valid = '0;
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) do_single(vecs[i]);

    // Round-robin fairness from ptr = 0, all four requesters held valid.
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = (i + 1) * 1024;
      req_b[i*DW +: DW] = 1024;
    end
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (n == 8) req_valid = '0;
      #1;
      if (n < 8) chk("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
      chk("rr_resp_valid", 32'(resp_valid), 32'(n >= 2));
      if (n >= 2) begin
        chk("rr_resp_id", 32'(resp_id), 32'((n - 2) % 4));
        chk("rr_resp_data", resp_data, 32'((((n - 2) % 4) + 1) * 1024));
      end
      tick();
    end

    // Backpressure on a stream from requester 2.
    idx = 0;
    got = 0;
    q.delete();
    for (int c = 0; c < 20; c++) begin
      resp_ready = !(c >= 2 && c <= 4);
      req_valid  = (idx < 5) ? 4'b0100 : 4'b0000;
      req_a[2*DW +: DW] = (idx + 1) * 1000;
      req_b[2*DW +: DW] = -2048;
      #1;
      exp_front = (q.size() > 0) ? q[0] : 32'hdeadbeef;
      if (c >= 2 && c <= 4) begin
        chk("bp_req_ready_stall", 32'(req_ready), 32'd0);
        chk("bp_resp_valid_hold", 32'(resp_valid), 32'd1);
        chk("bp_resp_data_hold", resp_data, exp_front);
      end
      if (resp_valid && resp_ready) begin
        chk("bp_resp_data", resp_data, exp_front);
        chk("bp_resp_id", 32'(resp_id), 32'd2);
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
      if (req_ready[2]) begin
        q.push_back(32'(-(idx + 1) * 2000));
        idx++;
      end
      tick();
    end
    chk("bp_count", 32'(got), 32'd5);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);
    resp_ready = 1'b1;

    // Pointer skip: only requesters 1 and 3 valid, starting at ptr = 0.
    apply_reset();
    req_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("skip_grant", 32'(req_ready), (n % 2 == 0) ? 32'b0010 : 32'b1000);
      tick();
    end
    req_valid = 4'b1111;
    #1;
    chk("skip_wrap_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();

    // Reset with both stages full; last accepted requester is 1 (ptr = 2).
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    req_a[1*DW +: DW] = 7 * 1024;
    req_b[1*DW +: DW] = 1024;
    #1;
    chk("mid_fill0", 32'(req_ready), 32'b0010);
    tick();
    #1;
    chk("mid_fill1", 32'(req_ready), 32'b0010);
    tick();
    #1;
    chk("mid_full_valid", 32'(resp_valid), 32'd1);
    chk("mid_full_stall", 32'(req_ready), 32'd0);
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = (i + 10) * 1024;
      req_b[i*DW +: DW] = 1024;
    end
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    reset_n    = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_resp_data", resp_data, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("mid_post_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #1;
    chk("mid_no_stale", 32'(resp_valid), 32'd0);
    tick();
    #1;
    chk("mid_first_valid", 32'(resp_valid), 32'd1);
    chk("mid_first_id", 32'(resp_id), 32'd0);
    chk("mid_first_data", resp_data, 32'd10240);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
